// File: rtl/ctl_round.sv
// Game-flow controller for one player's duck rounds: launches ducks, tracks
// ammo and round number, and decides hit, escape and game over.
module ctl_round #(
    parameter int AMMO_PER_ROUND  = 3,
    parameter int ROUNDS_PER_GAME = 10,
    parameter int ESCAPE_FRAMES   = 600,
    parameter int PAUSE_FRAMES    = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_frame,
    input  logic       start,
    input  logic       shot_fired,
    input  logic       hit,
    output logic       duck_launch,
    output logic       duck_active,
    output logic       duck_escaped,
    output logic       score_reset,
    output logic       game_over,
    output logic [3:0] ammo_ones,
    output logic [3:0] ammo_tens,
    output logic [3:0] round_ones,
    output logic [3:0] round_tens
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LAUNCH       = 3'd1,
        FLYING       = 3'd2,
        HIT_PAUSE    = 3'd3,
        ESCAPE_PAUSE = 3'd4,
        GAME_OVER    = 3'd5
    } state_t;

    localparam logic [6:0]  AMMO_LOAD  = 7'(AMMO_PER_ROUND);
    localparam logic [6:0]  ROUND_LAST = 7'(ROUNDS_PER_GAME);
    localparam logic [15:0] ESC_LIMIT  = 16'(ESCAPE_FRAMES);
    localparam logic [15:0] PAUSE_LIM  = 16'(PAUSE_FRAMES);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [6:0]  r_ammo;
    logic [6:0]  w_ammo_nxt;
    logic [6:0]  r_round;
    logic [6:0]  w_round_nxt;
    logic [15:0] r_frame;
    logic [15:0] w_frame_nxt;
    logic [15:0] w_frame_inc;
    logic        w_launch_nxt;
    logic        w_escaped_nxt;
    logic        w_score_reset_nxt;

    // Binary 0..99 to {tens, ones} BCD.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign w_frame_inc = r_frame + 16'd1;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ammo  <= 7'd0;
            r_round <= 7'd0;
            r_frame <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ammo  <= w_ammo_nxt;
            r_round <= w_round_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // Next-state, counter and pulse decode; hit outranks both escape causes.
    always_comb begin
        w_state_nxt       = r_state;
        w_ammo_nxt        = r_ammo;
        w_round_nxt       = r_round;
        w_frame_nxt       = r_frame;
        w_launch_nxt      = 1'b0;
        w_escaped_nxt     = 1'b0;
        w_score_reset_nxt = 1'b0;
        case (r_state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    w_state_nxt       = LAUNCH;
                    w_score_reset_nxt = 1'b1;
                    w_round_nxt       = 7'd1;
                    w_ammo_nxt        = AMMO_LOAD;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            LAUNCH: begin
                w_state_nxt  = FLYING;
                w_launch_nxt = 1'b1;
                w_frame_nxt  = 16'd0;
            end
            FLYING: begin
                if (shot_fired && (r_ammo != 7'd0)) begin
                    w_ammo_nxt = r_ammo - 7'd1;
                end else begin
                    w_ammo_nxt = r_ammo;
                end
                if (hit) begin
                    w_state_nxt = HIT_PAUSE;
                    w_frame_nxt = 16'd0;
                end else if (shot_fired && (r_ammo == 7'd1)) begin
                    w_state_nxt   = ESCAPE_PAUSE;
                    w_escaped_nxt = 1'b1;
                    w_frame_nxt   = 16'd0;
                end else if (new_frame) begin
                    if (w_frame_inc == ESC_LIMIT) begin
                        w_state_nxt   = ESCAPE_PAUSE;
                        w_escaped_nxt = 1'b1;
                        w_frame_nxt   = 16'd0;
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end else begin
                    w_frame_nxt = r_frame;
                end
            end
            HIT_PAUSE, ESCAPE_PAUSE: begin
                if (new_frame) begin
                    if (w_frame_inc == PAUSE_LIM) begin
                        w_frame_nxt = 16'd0;
                        if (r_round == ROUND_LAST) begin
                            w_state_nxt = GAME_OVER;
                        end else begin
                            w_state_nxt = LAUNCH;
                            w_round_nxt = r_round + 7'd1;
                            w_ammo_nxt  = AMMO_LOAD;
                        end
                    end else begin
                        w_frame_nxt = w_frame_inc;
                    end
                end else begin
                    w_frame_nxt = r_frame;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, derived from the values being loaded this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duck_launch  <= 1'b0;
            duck_active  <= 1'b0;
            duck_escaped <= 1'b0;
            score_reset  <= 1'b0;
            game_over    <= 1'b0;
            {ammo_tens, ammo_ones}   <= 8'd0;
            {round_tens, round_ones} <= 8'd0;
        end else begin
            duck_launch  <= w_launch_nxt;
            duck_active  <= (w_state_nxt == FLYING);
            duck_escaped <= w_escaped_nxt;
            score_reset  <= w_score_reset_nxt;
            game_over    <= (w_state_nxt == GAME_OVER);
            {ammo_tens, ammo_ones}   <= to_bcd(w_ammo_nxt);
            {round_tens, round_ones} <= to_bcd(w_round_nxt);
        end
    end

endmodule

// File: tb/tb_ctl_round.sv
// Directed testbench for ctl_round with small parameters
// (ammo 3, 2 rounds, escape after 5 frames, pause of 2 frames).
module tb_ctl_round;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_frame = 1'b0;
    logic       start = 1'b0;
    logic       shot_fired = 1'b0;
    logic       hit = 1'b0;
    logic       duck_launch, duck_active, duck_escaped, score_reset, game_over;
    logic [3:0] ammo_ones, ammo_tens, round_ones, round_tens;
    logic [7:0] ammo_v, round_v;
    int         checks = 0;
    int         fails = 0;

    assign ammo_v  = {ammo_tens, ammo_ones};
    assign round_v = {round_tens, round_ones};

    ctl_round #(
        .AMMO_PER_ROUND(3), .ROUNDS_PER_GAME(2), .ESCAPE_FRAMES(5), .PAUSE_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .new_frame(new_frame), .start(start),
        .shot_fired(shot_fired), .hit(hit), .duck_launch(duck_launch),
        .duck_active(duck_active), .duck_escaped(duck_escaped),
        .score_reset(score_reset), .game_over(game_over),
        .ammo_ones(ammo_ones), .ammo_tens(ammo_tens),
        .round_ones(round_ones), .round_tens(round_tens)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected inputs, then sample just after the edge.
    task automatic pulse(input logic s, input logic h, input logic f, input logic st);
        shot_fired = s; hit = h; new_frame = f; start = st;
        tick();
        shot_fired = 1'b0; hit = 1'b0; new_frame = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({duck_launch, duck_active, duck_escaped, score_reset, game_over} !== 5'b00000) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000",
                {duck_launch, duck_active, duck_escaped, score_reset, game_over});
        end
        checks++;
        if ({ammo_v, round_v} !== 16'h0000) begin
            fails++; $display("FAIL reset_digits: got %h expected 0000", {ammo_v, round_v});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_start();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({score_reset, duck_launch} !== 2'b10) begin
            fails++; $display("FAIL start_score_reset: got %b expected 10", {score_reset, duck_launch});
        end
        tick();
        checks++;
        if ({score_reset, duck_launch, duck_active} !== 3'b011) begin
            fails++; $display("FAIL start_launch: got %b expected 011",
                {score_reset, duck_launch, duck_active});
        end
        checks++;
        if ({ammo_v, round_v} !== 16'h0301) begin
            fails++; $display("FAIL start_digits: got %h expected 0301", {ammo_v, round_v});
        end
        tick();
        checks++;
        if (duck_launch !== 1'b0) begin
            fails++; $display("FAIL launch_one_cycle: got %b expected 0", duck_launch);
        end
    endtask

    task automatic test_ammo_escape();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ammo_v, duck_escaped, duck_active} !== 10'b0000_0010_0_1) begin
            fails++; $display("FAIL shot1: got ammo %h esc %b act %b expected 02 0 1",
                ammo_v, duck_escaped, duck_active);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ammo_v !== 8'h01) begin
            fails++; $display("FAIL shot2: got ammo %h expected 01", ammo_v);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ammo_v, duck_escaped, duck_active} !== 10'b0000_0000_1_0) begin
            fails++; $display("FAIL shot3_escape: got ammo %h esc %b act %b expected 00 1 0",
                ammo_v, duck_escaped, duck_active);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({duck_escaped, duck_launch, round_v} !== 10'b0_0_0000_0001) begin
            fails++; $display("FAIL pause_frame1: got esc %b launch %b round %h expected 0 0 01",
                duck_escaped, duck_launch, round_v);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({duck_launch, duck_active, round_v, ammo_v} !== 18'b1_1_0000_0010_0000_0011) begin
            fails++; $display("FAIL relaunch: got launch %b act %b round %h ammo %h expected 1 1 02 03",
                duck_launch, duck_active, round_v, ammo_v);
        end
    endtask

    task automatic test_timeout_and_game_over();
        repeat (4) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({duck_escaped, duck_active} !== 2'b01) begin
            fails++; $display("FAIL frames1to4: got esc %b act %b expected 0 1", duck_escaped, duck_active);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({duck_escaped, duck_active} !== 2'b10) begin
            fails++; $display("FAIL timeout_escape: got esc %b act %b expected 1 0", duck_escaped, duck_active);
        end
        repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({game_over, duck_launch, round_v} !== 10'b1_0_0000_0010) begin
            fails++; $display("FAIL game_over1: got go %b launch %b round %h expected 1 0 02",
                game_over, duck_launch, round_v);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({score_reset, game_over, round_v, ammo_v} !== 18'b1_0_0000_0001_0000_0011) begin
            fails++; $display("FAIL restart1: got sr %b go %b round %h ammo %h expected 1 0 01 03",
                score_reset, game_over, round_v, ammo_v);
        end
        repeat (2) tick();
    endtask

    task automatic test_hit_with_shot();
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ammo_v, duck_escaped, duck_active} !== 10'b0000_0010_0_0) begin
            fails++; $display("FAIL hit_shot: got ammo %h esc %b act %b expected 02 0 0",
                ammo_v, duck_escaped, duck_active);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({ammo_v, duck_escaped, duck_active} !== 10'b0000_0010_0_0) begin
            fails++; $display("FAIL pause_shot_ignored: got ammo %h esc %b act %b expected 02 0 0",
                ammo_v, duck_escaped, duck_active);
        end
        repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({duck_launch, round_v, ammo_v} !== 17'b1_0000_0010_0000_0011) begin
            fails++; $display("FAIL hit_relaunch: got launch %b round %h ammo %h expected 1 02 03",
                duck_launch, round_v, ammo_v);
        end
        tick();
    endtask

    task automatic test_hit_on_timeout_frame();
        repeat (4) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({duck_escaped, duck_active} !== 2'b00) begin
            fails++; $display("FAIL hit_beats_timeout: got esc %b act %b expected 0 0", duck_escaped, duck_active);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (game_over !== 1'b0) begin
            fails++; $display("FAIL pause_not_done: got go %b expected 0", game_over);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if ({game_over, duck_launch, round_v} !== 10'b1_0_0000_0010) begin
            fails++; $display("FAIL game_over2: got go %b launch %b round %h expected 1 0 02",
                game_over, duck_launch, round_v);
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({score_reset, round_v} !== 9'b1_0000_0001) begin
            fails++; $display("FAIL restart2: got sr %b round %h expected 1 01", score_reset, round_v);
        end
        tick();
        checks++;
        if (duck_launch !== 1'b1) begin
            fails++; $display("FAIL restart2_launch: got %b expected 1", duck_launch);
        end
    endtask

    task automatic test_reset_mid_game();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ammo_v, duck_active} !== 9'b0000_0001_1) begin
            fails++; $display("FAIL pre_reset: got ammo %h act %b expected 01 1", ammo_v, duck_active);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({duck_launch, duck_active, duck_escaped, score_reset, game_over, ammo_v, round_v}
                !== 21'd0) begin
            fails++; $display("FAIL async_reset: got act %b ammo %h round %h expected 0 00 00",
                duck_active, ammo_v, round_v);
        end
        #3 rst = 1'b1;
        tick();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({duck_launch, duck_active, duck_escaped, ammo_v, round_v} !== 19'd0) begin
            fails++; $display("FAIL shot_after_reset: got launch %b act %b ammo %h round %h expected 0 0 00 00",
                duck_launch, duck_active, ammo_v, round_v);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ammo_escape();
        test_timeout_and_game_over();
        test_hit_with_shot();
        test_hit_on_timeout_frame();
        test_reset_mid_game();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ctl_round.md
Name: ctl_round

Overview:
- Game-flow controller for one player's duck rounds.
- Sits between ctl_trigger (shot_fired/hit) and the duck/score/display logic.
- Launches each duck, tracks ammo per duck and the round number, and decides hit, escape and game over.
- Drives the ammo and round digits that disp_hex_mux currently receives as constants.

Parameters:
AMMO_PER_ROUND, 3, shots per duck; legal range 1..99
ROUNDS_PER_GAME, 10, ducks per game; legal range 1..99
ESCAPE_FRAMES, 600, frames a duck may fly before escaping; legal range 1..65535
PAUSE_FRAMES, 90, frames of pause after a hit or escape; legal range 1..65535

Ports:
clk  in  1  main 65 MHz clock; single clock domain
rst  in  1  asynchronous, active-low reset
new_frame  in  1  one-cycle pulse per VGA frame from vga_timing
start  in  1  one-cycle start request, already debounced and synchronised
shot_fired  in  1  one-cycle pulse from ctl_trigger
hit  in  1  one-cycle pulse from ctl_trigger
duck_launch  out  1  one-cycle pulse: ctl_duck loads a new start position
duck_active  out  1  high while the duck is in flight and shots count
duck_escaped  out  1  one-cycle pulse when the duck escapes
score_reset  out  1  one-cycle pulse to ctl_score at game start
game_over  out  1  level, high in GAME_OVER
ammo_ones  out  4  BCD ones digit of remaining ammo
ammo_tens  out  4  BCD tens digit of remaining ammo
round_ones  out  4  BCD ones digit of the current round
round_tens  out  4  BCD tens digit of the current round

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All pulse outputs are 0, and duck_active and game_over are 0.
  - Ammo and round digits are 0, and the frame counter is 0.
- All outputs are registered.
- States: IDLE, LAUNCH, FLYING, HIT_PAUSE, ESCAPE_PAUSE, GAME_OVER.
- IDLE, on start:
  - Next cycle: score_reset=1 for one cycle.
  - Round is set to 1 and ammo to AMMO_PER_ROUND.
  - State goes to LAUNCH.
- LAUNCH:
  - duck_launch=1 for exactly one cycle.
  - The frame counter is cleared.
  - State goes to FLYING on the next cycle.
- FLYING (duck_active=1):
  - shot_fired with ammo>0: ammo decrements by 1.
  - shot_fired with ammo==0: ignored.
  - hit (with or without shot_fired in the same cycle): goes to HIT_PAUSE. Hit has priority over every escape condition in the same cycle. Any coincident shot still decrements ammo.
  - Ammo escape: shot_fired takes ammo from 1 to 0 without hit. duck_escaped pulses on the transition cycle and the state goes to ESCAPE_PAUSE.
  - Each new_frame increments the frame counter.
  - Timeout escape: the counter reaches ESCAPE_FRAMES, with no hit that cycle. duck_escaped pulses and the state goes to ESCAPE_PAUSE.
- HIT_PAUSE and ESCAPE_PAUSE:
  - duck_active=0; shot_fired and hit are ignored.
  - The frame counter is cleared on entry and counts new_frame pulses.
  - When it reaches PAUSE_FRAMES:
    - If round==ROUNDS_PER_GAME, the state goes to GAME_OVER.
    - Otherwise round increments, ammo reloads to AMMO_PER_ROUND, and the state goes to LAUNCH.
- GAME_OVER:
  - game_over=1; the digits hold their last values.
  - start behaves exactly as start in IDLE.
- start is ignored in LAUNCH, FLYING and both pause states.
- Digit encoding:
  - Ammo and round are held as binary counters, 7 bits each, and converted to two BCD digits.
  - Parameter ranges guarantee values never exceed 99.
  - The frame counter is 16 bits and never wraps within legal parameters.
- new_frame coinciding with hit or with the ammo escape: the event decides the transition, and the counter increment is discarded.
- Reset mid-game (any state): immediate return to the reset values; no pulses are emitted.

Test Plan:
Test parameters for all scenarios: AMMO_PER_ROUND=3, ROUNDS_PER_GAME=2, ESCAPE_FRAMES=5, PAUSE_FRAMES=2.
1. Reset then start pulse:
   - score_reset pulses, then duck_launch pulses exactly one cycle later.
   - duck_active=1, ammo digits 0/3, round digits 0/1.
2. Three shot_fired pulses with no hit:
   - Ammo reads 2, then 1.
   - The third shot pulses duck_escaped and duck_active drops.
   - After 2 new_frame pulses: duck_launch, round 0/2, ammo 0/3.
3. In round 1, shot_fired+hit in the same cycle on the first shot:
   - Ammo reads 2, HIT_PAUSE is entered, and duck_escaped is never asserted.
   - A later shot_fired during the pause leaves ammo at 2.
4. In FLYING, 5 new_frame pulses with no shots:
   - duck_escaped pulses on the 5th.
   - hit and new_frame coinciding on the 5th instead gives HIT_PAUSE and no escape.
5. Complete round 2 by hit, then 2 frames:
   - game_over=1, round digits hold 0/2, no duck_launch.
   - start gives score_reset and round 0/1.
6. Assert rst low during FLYING with ammo 1:
   - All outputs go to 0 asynchronously and the state is IDLE.
   - shot_fired after release has no effect.
